// File: rtl/wb_pkg.sv
// Shared types for the Wishbone classic master: core command encoding
// and master FSM states.
package wb_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    LOAD  = 2'b01,
    STORE = 2'b10
  } wb_command_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    DONE   = 2'b10
  } wb_master_state_t;

endpackage

// File: rtl/wb_watchdog.sv
// Bus-cycle watchdog: reloads on clear, counts down while enabled and
// flags expiry on the last allowed wait cycle.
module wb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic clear_in,
  input  logic enable_in,
  output logic expired_out
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] START_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_in) begin
      cnt_d = START_VAL;
    end else if (enable_in && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      cnt_q <= START_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_out = enable_in && (cnt_q == '0);

endmodule

// File: rtl/wb_classic_master.sv
// Wishbone B4 classic single-cycle master for the load/store unit.
// Optional watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_classic_master
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic [1:0]              cmd_in,
  input  logic [ADDR_WIDTH-1:0]   addr_in,
  input  logic [DATA_WIDTH-1:0]   wdata_in,
  input  logic [DATA_WIDTH/8-1:0] wmask_in,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    err_out,
  output logic [DATA_WIDTH-1:0]   rdata_out,
  output logic                    wb_cyc_out,
  output logic                    wb_stb_out,
  output logic                    wb_we_out,
  output logic [ADDR_WIDTH-1:0]   wb_adr_out,
  output logic [DATA_WIDTH-1:0]   wb_dat_out,
  output logic [DATA_WIDTH/8-1:0] wb_sel_out,
  input  logic [DATA_WIDTH-1:0]   wb_dat_in,
  input  logic                    wb_ack_in,
  input  logic                    wb_err_in
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

  if ((DATA_WIDTH % 8 != 0) || (TIMEOUT_CYCLES < 2)) begin : g_bad_param
    $error("wb_classic_master: invalid DATA_WIDTH or TIMEOUT_CYCLES");
  end

  wb_master_state_t      state_q, state_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  accept;
  logic                  timeout;

  assign accept = (state_q == IDLE) &&
                  ((cmd_in == LOAD) || (cmd_in == STORE));

`ifdef WB_MASTER_TIMEOUT_EN
  wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .clear_in   (accept),
    .enable_in  ((state_q == ACTIVE) && !wb_ack_in && !wb_err_in),
    .expired_out(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    err_d   = err_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACTIVE;
          adr_d   = addr_in;
          dat_d   = wdata_in;
          we_d    = (cmd_in == STORE);
          sel_d   = (cmd_in == STORE) ? wmask_in : '1;
        end
      end
      ACTIVE: begin
        // err outranks ack; the watchdog only fires with no termination
        if (wb_err_in) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (wb_ack_in) begin
          err_d   = 1'b0;
          state_d = DONE;
          if (!we_q) begin
            rdata_d = wb_dat_in;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy_out   = (state_q == ACTIVE);
  assign wb_cyc_out = (state_q == ACTIVE);
  assign wb_stb_out = (state_q == ACTIVE);
  assign done_out   = (state_q == DONE);
  assign err_out    = err_q;
  assign rdata_out  = rdata_q;
  assign wb_we_out  = we_q;
  assign wb_adr_out = adr_q;
  assign wb_dat_out = dat_q;
  assign wb_sel_out = sel_q;

endmodule

// File: tb/tb_wb_classic_master.sv
// Directed bench for wb_classic_master with hand-computed expectations.
module tb_wb_classic_master;

  logic        clk_in;
  logic        reset_in;
  logic [1:0]  cmd_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic [3:0]  wmask_in;
  logic        busy_out;
  logic        done_out;
  logic        err_out;
  logic [31:0] rdata_out;
  logic        wb_cyc_out;
  logic        wb_stb_out;
  logic        wb_we_out;
  logic [31:0] wb_adr_out;
  logic [31:0] wb_dat_out;
  logic [3:0]  wb_sel_out;
  logic [31:0] wb_dat_in;
  logic        wb_ack_in;
  logic        wb_err_in;

  int n_vec;
  int n_err;
  int n_cyc;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_LOAD  = 2'b01;
  localparam logic [1:0] C_STORE = 2'b10;

  wb_classic_master #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .cmd_in    (cmd_in),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .wmask_in  (wmask_in),
    .busy_out  (busy_out),
    .done_out  (done_out),
    .err_out   (err_out),
    .rdata_out (rdata_out),
    .wb_cyc_out(wb_cyc_out),
    .wb_stb_out(wb_stb_out),
    .wb_we_out (wb_we_out),
    .wb_adr_out(wb_adr_out),
    .wb_dat_out(wb_dat_out),
    .wb_sel_out(wb_sel_out),
    .wb_dat_in (wb_dat_in),
    .wb_ack_in (wb_ack_in),
    .wb_err_in (wb_err_in)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [1:0] c, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    cmd_in   = c;
    addr_in  = a;
    wdata_in = d;
    wmask_in = m;
    tick();
    cmd_in = C_NONE;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset_in  = 1'b1;
    cmd_in    = C_NONE;
    addr_in   = '0;
    wdata_in  = '0;
    wmask_in  = '0;
    wb_dat_in = '0;
    wb_ack_in = 1'b0;
    wb_err_in = 1'b0;
    tick();
    tick();
    check("rst_cyc", {63'd0, wb_cyc_out}, 64'd0);
    check("rst_stb", {63'd0, wb_stb_out}, 64'd0);
    check("rst_busy_done_err", {61'd0, busy_out, done_out, err_out}, 64'd0);
    check("rst_we_sel", {59'd0, wb_we_out, wb_sel_out}, 64'd0);
    check("rst_adr_dat", {wb_adr_out, wb_dat_out}, 64'd0);
    check("rst_rdata", {32'd0, rdata_out}, 64'd0);
    reset_in = 1'b0;
    tick();
    check("idle_none", {62'd0, wb_cyc_out, busy_out}, 64'd0);

    // LOAD, slave acks in the first ACTIVE cycle
    issue(C_LOAD, 32'h0000_1000, 32'h1234_5678, 4'h0);
    check("ld_cyc_stb_busy", {61'd0, wb_cyc_out, wb_stb_out, busy_out}, 64'h7);
    check("ld_we_sel", {59'd0, wb_we_out, wb_sel_out}, 64'hF);
    check("ld_adr", {32'd0, wb_adr_out}, 64'h1000);
    check("ld_done_early", {63'd0, done_out}, 64'd0);
    wb_ack_in = 1'b1;
    wb_dat_in = 32'h0012_8293;
    tick();
    wb_ack_in = 1'b0;
    wb_dat_in = 32'h0;
    check("ld_cyc_drop", {62'd0, wb_cyc_out, busy_out}, 64'd0);
    check("ld_done_err", {62'd0, done_out, err_out}, 64'h2);
    check("ld_rdata", {32'd0, rdata_out}, 64'h0012_8293);
    tick();
    check("ld_done_pulse", {63'd0, done_out}, 64'd0);

    // STORE with three wait cycles
    issue(C_STORE, 32'h0000_2004, 32'hDEAD_BEEF, 4'b0011);
    for (int i = 0; i < 4; i++) begin
      check("st_cyc", {62'd0, wb_cyc_out, wb_stb_out}, 64'h3);
      check("st_adr_dat", {wb_adr_out, wb_dat_out}, 64'h0000_2004_DEAD_BEEF);
      check("st_we_sel", {59'd0, wb_we_out, wb_sel_out}, 64'h13);
      if (i == 3) begin
        wb_ack_in = 1'b1;
        wb_dat_in = 32'h5555_5555;
      end
      tick();
    end
    wb_ack_in = 1'b0;
    check("st_done_err", {62'd0, done_out, err_out}, 64'h2);
    check("st_rdata_hold", {32'd0, rdata_out}, 64'h0012_8293);
    tick();

    // ack and err together: err wins, rdata held
    issue(C_LOAD, 32'h0000_3000, 32'h0, 4'h0);
    wb_ack_in = 1'b1;
    wb_err_in = 1'b1;
    wb_dat_in = 32'hFFFF_FFFF;
    tick();
    wb_ack_in = 1'b0;
    wb_err_in = 1'b0;
    check("ackerr_done_err", {62'd0, done_out, err_out}, 64'h3);
    check("ackerr_rdata", {32'd0, rdata_out}, 64'h0012_8293);
    tick();

    // err alone on a LOAD
    issue(C_LOAD, 32'h0000_3004, 32'h0, 4'h0);
    tick();
    wb_err_in = 1'b1;
    tick();
    wb_err_in = 1'b0;
    check("err_done_err", {62'd0, done_out, err_out}, 64'h3);
    tick();

    // silent slave
    issue(C_LOAD, 32'h0000_4000, 32'h0, 4'h0);
    n_cyc = 0;
    while (wb_cyc_out && n_cyc < 120) begin
      n_cyc++;
      tick();
    end
`ifdef WB_MASTER_TIMEOUT_EN
    check("to_cycles", 64'(n_cyc), 64'd8);
    check("to_done_err", {62'd0, done_out, err_out}, 64'h3);
    tick();
`else
    check("noto_cycles", 64'(n_cyc), 64'd120);
    check("noto_cyc_high", {63'd0, wb_cyc_out}, 64'd1);
    wb_ack_in = 1'b1;
    wb_dat_in = 32'h0BAD_F00D;
    tick();
    wb_ack_in = 1'b0;
    check("noto_done_err", {62'd0, done_out, err_out}, 64'h2);
    check("noto_rdata", {32'd0, rdata_out}, 64'h0BAD_F00D);
    tick();
`endif

    // reset asserted mid-ACTIVE between edges
    issue(C_LOAD, 32'h0000_5000, 32'h0, 4'h0);
    check("mid_cyc_before", {63'd0, wb_cyc_out}, 64'd1);
    #2;
    reset_in = 1'b1;
    #1;
    check("mid_rst_drop", {61'd0, wb_cyc_out, wb_stb_out, busy_out}, 64'd0);
    tick();
    check("mid_rst_no_done", {63'd0, done_out}, 64'd0);
    check("mid_rst_rdata", {32'd0, rdata_out}, 64'd0);
    reset_in = 1'b0;
    tick();
    check("post_rst_no_done", {63'd0, done_out}, 64'd0);
    issue(C_LOAD, 32'h0000_0040, 32'h0, 4'h0);
    check("post_rst_adr", {32'd0, wb_adr_out}, 64'h40);
    wb_ack_in = 1'b1;
    wb_dat_in = 32'hA5A5_0001;
    tick();
    wb_ack_in = 1'b0;
    check("post_rst_done", {62'd0, done_out, err_out}, 64'h2);
    check("post_rst_rdata", {32'd0, rdata_out}, 64'hA5A5_0001);
    tick();

    // STORE held through an in-flight LOAD
    issue(C_LOAD, 32'h0000_6000, 32'h0, 4'h0);
    cmd_in   = C_STORE;
    addr_in  = 32'h0000_7000;
    wdata_in = 32'h1122_3344;
    wmask_in = 4'hF;
    check("hold_ld_adr", {32'd0, wb_adr_out}, 64'h6000);
    check("hold_ld_we", {63'd0, wb_we_out}, 64'd0);
    wb_ack_in = 1'b1;
    wb_dat_in = 32'h7777_0000;
    tick();
    wb_ack_in = 1'b0;
    check("hold_done", {62'd0, done_out, wb_cyc_out}, 64'h2);
    tick();
    check("hold_idle", {62'd0, wb_cyc_out, done_out}, 64'd0);
    tick();
    check("hold_st_cyc", {62'd0, wb_cyc_out, wb_we_out}, 64'h3);
    check("hold_st_adr", {wb_adr_out, wb_dat_out}, 64'h0000_7000_1122_3344);
    cmd_in    = C_NONE;
    wb_ack_in = 1'b1;
    tick();
    wb_ack_in = 1'b0;
    check("hold_st_done", {62'd0, done_out, err_out}, 64'h2);
    check("hold_rdata", {32'd0, rdata_out}, 64'h7777_0000);
    tick();
    check("hold_end_idle", {63'd0, wb_cyc_out}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
